external_interrupt_controller: RTL and testbench

- Collects edge-triggered interrupt lines from memory-mapped peripherals.
- Drives the CSR unit's external interrupt request and its external interrupt code.
- Tracks per-source pending/in-service state.
- Software services sources through a claim/complete register pair. The handler reads the code from this block, never from mcause alone.

---
 rtl/external_interrupt_controller_if.sv | 26 ++
 rtl/external_interrupt_controller.sv | 84 ++++++++
 tb/tb_external_interrupt_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/external_interrupt_controller_if.sv
// external_interrupt_controller_if: register bus, interrupt lines and CSR-unit request for the external interrupt controller
// Ports: master drives irqSrc and the register strobes/address/write data;
//        slave (the controller) returns read data/valid and the external interrupt request/code.
interface external_interrupt_controller_if #(
    parameter int NUM_SOURCES = 8,
    parameter int CODE_WIDTH  = 5
);
    logic [NUM_SOURCES-1:0] irqSrc;
    logic                   regRE;
    logic                   regWE;
    logic [1:0]             regAddr;
    logic [31:0]            regWriteData;
    logic [31:0]            regReadData;
    logic                   regReadValid;
    logic                   reqExternalInterrupt;
    logic [CODE_WIDTH-1:0]  externalInterruptCode;

    modport master (
        output irqSrc, regRE, regWE, regAddr, regWriteData,
        input  regReadData, regReadValid, reqExternalInterrupt, externalInterruptCode
    );
    modport slave (
        input  irqSrc, regRE, regWE, regAddr, regWriteData,
        output regReadData, regReadValid, reqExternalInterrupt, externalInterruptCode
    );
endinterface

// File: rtl/external_interrupt_controller.sv
// external_interrupt_controller: edge-triggered interrupt collector with per-source pending/in-service tracking and claim/complete
// Ports: clk, rst (sync, active-high); bus (slave modport) carries irqSrc, the register
//        read/write port (PENDING, ENABLE, CLAIM_COMPLETE, STATUS) and the CSR-unit request/code.
module external_interrupt_controller #(
    parameter int NUM_SOURCES = 8,
    parameter int CODE_WIDTH  = 5
) (
    input logic                           clk,
    input logic                           rst,
    external_interrupt_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PENDING, IN_SERVICE} src_state_t;

    src_state_t             state [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] prev, relatch, enable, pend_vec, insvc_vec, edge_det, claim, complete;
    logic [CODE_WIDTH-1:0]  win;
    logic [31:0]            read_mux;

    assign edge_det = bus.irqSrc & ~prev;

    // Scanning downward leaves the lowest-index pending-and-enabled source as the winner.
    always_comb begin
        win       = '0;
        pend_vec  = '0;
        insvc_vec = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            pend_vec[i]  = state[i] == PENDING;
            insvc_vec[i] = state[i] == IN_SERVICE;
            if (pend_vec[i] && enable[i]) win = CODE_WIDTH'(i + 1);
        end
    end

    // Full-width compare on completes so codes 0 and > NUM_SOURCES never match a source.
    always_comb begin
        claim    = '0;
        complete = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            claim[i]    = bus.regRE && bus.regAddr == 2'd2 && win == CODE_WIDTH'(i + 1);
            complete[i] = bus.regWE && bus.regAddr == 2'd2 && bus.regWriteData == 32'(i + 1);
        end
    end

    // Claim returns the live winner code, not the registered output, so it is never stale.
    assign read_mux = bus.regAddr == 2'd0 ? 32'(pend_vec)
                    : bus.regAddr == 2'd1 ? 32'(enable)
                    : bus.regAddr == 2'd2 ? 32'(win)
                    : 32'(insvc_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SOURCES; i++) state[i] <= IDLE;
            prev                      <= '0;
            relatch                   <= '0;
            enable                    <= '0;
            bus.regReadData           <= '0;
            bus.regReadValid          <= 1'b0;
            bus.reqExternalInterrupt  <= 1'b0;
            bus.externalInterruptCode <= '0;
        end else begin
            prev                      <= bus.irqSrc;
            bus.regReadValid          <= bus.regRE;
            bus.regReadData           <= bus.regRE ? read_mux : '0;
            bus.reqExternalInterrupt  <= |(pend_vec & enable);
            bus.externalInterruptCode <= win;
            if (bus.regWE && bus.regAddr == 2'd1) enable <= bus.regWriteData[NUM_SOURCES-1:0];
            for (int i = 0; i < NUM_SOURCES; i++) begin
                case (state[i])
                    IDLE: if (edge_det[i]) state[i] <= PENDING;
                    PENDING: if (claim[i]) begin
                        state[i]   <= IN_SERVICE;
                        relatch[i] <= edge_det[i];
                    end
                    IN_SERVICE: if (complete[i]) begin
                        state[i]   <= (relatch[i] || edge_det[i]) ? PENDING : IDLE;
                        relatch[i] <= 1'b0;
                    end else if (edge_det[i]) relatch[i] <= 1'b1;
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(bus.regRE && bus.regWE));
endmodule

// File: tb/tb_external_interrupt_controller.sv
// tb_external_interrupt_controller: vector table plus hand sequences, read data checked through a scoreboard queue
module tb_external_interrupt_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    external_interrupt_controller_if #(.NUM_SOURCES(8), .CODE_WIDTH(5)) bus ();
    external_interrupt_controller #(.NUM_SOURCES(8), .CODE_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        re;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [7:0]  irq;
        logic        req;
        logic [4:0]  code;
        logic [31:0] rd;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string nm, input logic r, input logic [4:0] c);
        chk({nm, "_req"}, {31'b0, bus.reqExternalInterrupt}, {31'b0, r});
        chk({nm, "_code"}, {27'b0, bus.externalInterruptCode}, {27'b0, c});
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        bus.regRE   = 1'b1;
        bus.regAddr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        cyc();
        bus.regRE = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.regWE        = 1'b1;
        bus.regAddr      = a;
        bus.regWriteData = d;
        cyc();
        bus.regWE = 1'b0;
    endtask

    task automatic pulse(input int k);
        bus.irqSrc[k] = 1'b1;
        cyc();
        bus.irqSrc[k] = 1'b0;
        cyc();
    endtask

    always @(posedge clk) begin
        #2;
        if (bus.regReadValid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got valid data %h, required no read", bus.regReadData);
            end else begin
                automatic string       nm = name_q.pop_front();
                automatic logic [31:0] e  = exp_q.pop_front();
                chk(nm, bus.regReadData, e);
            end
        end
    end

    initial begin
        bus.irqSrc       = '0;
        bus.regRE        = 1'b0;
        bus.regWE        = 1'b0;
        bus.regAddr      = '0;
        bus.regWriteData = '0;
        // re, we, addr, wdata, irq, exp req, exp code, exp read data
        tbl.push_back('{1'b0, 1'b1, 2'd1, 32'h05, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'h00, 8'h04, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 32'h00, 8'h00, 1'b1, 5'd3, 32'h04});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 32'hFF, 8'h00, 1'b1, 5'd3, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'h00, 8'h05, 1'b1, 5'd3, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h00, 8'h00, 1'b1, 5'd1, 32'h01});
        tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h00, 8'h00, 1'b1, 5'd3, 32'h03});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 32'h00, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd3, 32'h00, 8'h00, 1'b0, 5'd0, 32'h05});
        tbl.push_back('{1'b0, 1'b1, 2'd2, 32'h01, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 2'd2, 32'h03, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 32'h00, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'h00, 8'h10, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'h00, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd0, 32'h00, 8'h00, 1'b0, 5'd0, 32'h10});
        tbl.push_back('{1'b0, 1'b1, 2'd1, 32'h10, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'h00, 8'h00, 1'b1, 5'd5, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h00, 8'h00, 1'b1, 5'd5, 32'h05});
        tbl.push_back('{1'b0, 1'b1, 2'd2, 32'h05, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h00, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd3, 32'h00, 8'h00, 1'b0, 5'd0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 2'd1, 32'h00, 8'h00, 1'b0, 5'd0, 32'h10});

        repeat (3) cyc();
        outs("reset", 1'b0, 5'd0);
        chk("reset_valid", {31'b0, bus.regReadValid}, 32'h0);
        chk("reset_data", bus.regReadData, 32'h0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            bus.regRE        = tbl[k].re;
            bus.regWE        = tbl[k].we;
            bus.regAddr      = tbl[k].addr;
            bus.regWriteData = tbl[k].wd;
            bus.irqSrc       = tbl[k].irq;
            if (tbl[k].re) begin
                exp_q.push_back(tbl[k].rd);
                name_q.push_back($sformatf("vec%0d_read", k));
            end
            cyc();
            outs($sformatf("vec%0d", k), tbl[k].req, tbl[k].code);
        end
        bus.regRE  = 1'b0;
        bus.regWE  = 1'b0;
        bus.irqSrc = '0;
        cyc();

        // one relatch level only while in service
        wr(2'd1, 32'hFF);
        pulse(1);
        outs("src1", 1'b1, 5'd2);
        rd(2'd2, 32'h02, "claim_src1");
        pulse(1);
        pulse(1);
        wr(2'd2, 32'h02);
        rd(2'd0, 32'h02, "pend_relatch_once");
        rd(2'd2, 32'h02, "reclaim_src1");
        wr(2'd2, 32'h02);
        rd(2'd0, 32'h00, "pend_after_complete");
        rd(2'd3, 32'h00, "status_after_complete");

        // invalid completes leave state untouched
        pulse(6);
        rd(2'd2, 32'h07, "claim_src6");
        wr(2'd2, 32'h00);
        wr(2'd2, 32'h09);
        wr(2'd2, 32'h03);
        rd(2'd3, 32'h40, "status_after_bad_completes");
        rd(2'd0, 32'h00, "pend_after_bad_completes");
        wr(2'd2, 32'h07);
        rd(2'd3, 32'h00, "status_after_complete7");

        // edge coinciding with claim, then with complete
        pulse(5);
        bus.irqSrc[5] = 1'b1;
        rd(2'd2, 32'h06, "claim_with_edge");
        bus.irqSrc[5] = 1'b0;
        rd(2'd3, 32'h20, "status_claim_with_edge");
        wr(2'd2, 32'h06);
        rd(2'd0, 32'h20, "pend_edge_claim");
        rd(2'd2, 32'h06, "claim5_again");
        bus.irqSrc[5] = 1'b1;
        wr(2'd2, 32'h06);
        bus.irqSrc[5] = 1'b0;
        rd(2'd0, 32'h20, "pend_edge_complete");
        rd(2'd2, 32'h06, "claim5_third");
        wr(2'd2, 32'h06);
        rd(2'd0, 32'h00, "pend_src5_done");

        // line held high through reset release, then reset while in service
        bus.irqSrc = 8'h08;
        rst = 1'b1;
        cyc();
        cyc();
        outs("rst_hold", 1'b0, 5'd0);
        rst = 1'b0;
        cyc();
        rd(2'd0, 32'h08, "pend_src3_after_reset");
        bus.irqSrc = 8'h00;
        wr(2'd1, 32'h08);
        cyc();
        outs("src3", 1'b1, 5'd4);
        rd(2'd2, 32'h04, "claim_src3");
        rd(2'd3, 32'h08, "status_src3");
        bus.regRE   = 1'b1;
        bus.regAddr = 2'd3;
        rst         = 1'b1;
        cyc();
        bus.regRE = 1'b0;
        outs("midreset", 1'b0, 5'd0);
        chk("midreset_valid", {31'b0, bus.regReadValid}, 32'h0);
        chk("midreset_data", bus.regReadData, 32'h0);
        rst = 1'b0;
        cyc();
        rd(2'd3, 32'h00, "status_after_midreset");
        rd(2'd1, 32'h00, "enable_after_midreset");
        cyc();
        cyc();

        while (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no read response, required %h", name_q.pop_front(), exp_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
